int_req_arb: RTL and testbench



---
 rtl/int_req_arb_if.sv | 29 ++
 rtl/int_req_arb.sv | 126 ++++++++++++
 tb/tb_int_req_arb.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_req_arb_if.sv
// Handshake bundle between the interrupt request arbiter and the interrupt controller.
// Slave modport is the arbiter's view; master is the controller/driver view.
interface int_req_arb_if;
  logic [2:0] in_IRQ;
  logic [2:0] in_mask;
  logic       in_NIE;
  logic       in_hold;
  logic       in_eret;
  logic [3:0] in_IG;
  logic       out_BK;
  logic [1:0] out_code;
  logic [2:0] out_pending;
  logic [2:0] out_insvc;
  logic       out_busy;
  logic [1:0] dbg_state;

  // out_BK is a one-cycle strobe with no ready: the controller must take it when it is high.
  // in_hold is the pipeline's back-pressure and only ever delays the strobe.
  // in_IG acknowledges one in-service source when the controller retires it.
  modport slave (
    input  in_IRQ, in_mask, in_NIE, in_hold, in_eret, in_IG,
    output out_BK, out_code, out_pending, out_insvc, out_busy, dbg_state
  );

  modport master (
    output in_IRQ, in_mask, in_NIE, in_hold, in_eret, in_IG,
    input  out_BK, out_code, out_pending, out_insvc, out_busy, dbg_state
  );
endinterface

// File: rtl/int_req_arb.sv
// Interrupt request arbiter: synchronises three IRQ lines, latches pending requests and issues breaks.
// Optional nested issue is enabled by defining INT_NEST_EN.
module int_req_arb (
  input  logic              in_CLK,
  input  logic              in_RST,
  int_req_arb_if.slave      bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam logic [1:0] ST_RET   = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] sync_prev;
  logic [2:0] rise;
  logic [2:0] pending;
  logic [2:0] insvc;
  logic [2:0] insvc_nxt;
  logic [2:0] eligible;
  logic       bk;
  logic [1:0] code;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       nest_ok;
  logic       issue;
  logic       unused_ig3;

  assign unused_ig3 = bus.in_IG[3];
  assign rise       = sync2 & ~sync_prev;

`ifdef INT_NEST_EN
  logic [1:0] svc_lvl;
  logic [1:0] win_lvl;

  // Levels are 1..3 for sources 0..2, so 0 means nothing is in service.
  always_comb begin
    svc_lvl = 2'd0;
    if (insvc[2])      svc_lvl = 2'd3;
    else if (insvc[1]) svc_lvl = 2'd2;
    else if (insvc[0]) svc_lvl = 2'd1;
    win_lvl = win_idx + 2'd1;
    nest_ok = (win_lvl > svc_lvl);
  end
`else
  always_comb begin
    nest_ok = (insvc == 3'b000);
  end
`endif

  always_comb begin
    eligible = pending & bus.in_mask & ~insvc;
    win_vld  = 1'b0;
    win_idx  = 2'd0;
    if (eligible[2]) begin
      win_vld = 1'b1;
      win_idx = 2'd2;
    end else if (eligible[1]) begin
      win_vld = 1'b1;
      win_idx = 2'd1;
    end else if (eligible[0]) begin
      win_vld = 1'b1;
      win_idx = 2'd0;
    end
  end

  // ERET takes precedence over a new issue in IDLE so the return window is never skipped.
  assign issue = (state == ST_IDLE) && !bus.in_eret && win_vld && nest_ok
                 && bus.in_NIE && !bus.in_hold;

  always_comb begin
    insvc_nxt = insvc & ~bus.in_IG[2:0];
    if (issue) insvc_nxt = insvc_nxt | (3'b001 << win_idx);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.in_eret) state_nxt = ST_RET;
                else if (issue) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_GUARD;
      ST_GUARD: state_nxt = bus.in_eret ? ST_RET : ST_IDLE;
      ST_RET:   state_nxt = bus.in_eret ? ST_RET : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      sync1     <= 3'b000;
      sync2     <= 3'b000;
      sync_prev <= 3'b000;
      pending   <= 3'b000;
      insvc     <= 3'b000;
      state     <= ST_IDLE;
      bk        <= 1'b0;
      code      <= 2'b00;
    end else begin
      sync1     <= bus.in_IRQ;
      sync2     <= sync1;
      sync_prev <= sync2;
      // A new edge wins over an acknowledge landing on the same cycle.
      pending   <= (pending & ~bus.in_IG[2:0]) | rise;
      insvc     <= insvc_nxt;
      state     <= state_nxt;
      if (issue) begin
        bk   <= 1'b1;
        code <= win_idx + 2'd1;
      end else begin
        bk   <= 1'b0;
        code <= 2'b00;
      end
    end
  end

  assign bus.out_BK      = bk;
  assign bus.out_code    = code;
  assign bus.out_pending = pending;
  assign bus.out_insvc   = insvc;
  assign bus.out_busy    = (state != ST_IDLE);
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_int_req_arb.sv
// Self-checking bench for int_req_arb: table-driven single-shot vectors plus multi-cycle sequences.
// Nested-issue expectations follow INT_NEST_EN.
module tb_int_req_arb;

  logic in_CLK = 1'b0;
  logic in_RST;

  int_req_arb_if bus();

  int_req_arb dut (
    .in_CLK (in_CLK),
    .in_RST (in_RST),
    .bus    (bus)
  );

  always #5 in_CLK = ~in_CLK;

  int         n_cmp = 0;
  int         n_err = 0;
  logic       prev_bk = 1'b0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [2:0] irq;
    logic [2:0] mask;
    logic       nie;
    logic       bk;
    logic [1:0] code;
    logic [2:0] pend;
    logic [2:0] insvc;
  } vec_t;

  vec_t vecs[7];

  // The arbiter must never see ERET while a break is on the wire.
  always @(negedge in_CLK) begin
    if (!in_RST) begin
      assert (!(bus.dbg_state == 2'd1 && bus.in_eret))
        else $error("eret driven during break issue");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected summary first");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every break seen must match the head of the expected-code queue.
  task automatic mon();
    logic [1:0] e;
    if (in_RST) begin
      prev_bk = 1'b0;
    end else begin
      if (bus.out_BK) begin
        chk("bk_width", 32'(prev_bk), 32'(0));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_bk: got break code %0d expected no break", bus.out_code);
        end else begin
          e = exp_q.pop_front();
          chk("bk_code", 32'(bus.out_code), 32'(e));
        end
      end else begin
        chk("idle_code", 32'(bus.out_code), 32'(0));
      end
      prev_bk = bus.out_BK;
    end
  endtask

  task automatic tick();
    @(negedge in_CLK);
    mon();
    @(posedge in_CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_irq(input logic [2:0] bits);
    bus.in_IRQ = bits;
    tick();
    bus.in_IRQ = 3'b000;
  endtask

  task automatic retire(input logic [2:0] ig);
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
    bus.in_IG   = {1'b0, ig};
    tick();
    bus.in_IG   = 4'b0000;
  endtask

  task automatic wait_bk(input int max_cyc, input string name);
    int k;
    k = 0;
    while (!bus.out_BK && k < max_cyc) begin
      tick();
      k++;
    end
    chk(name, 32'(bus.out_BK), 32'(1));
  endtask

  initial begin
    vecs[0] = '{3'b001, 3'b111, 1'b1, 1'b1, 2'b01, 3'b001, 3'b001};
    vecs[1] = '{3'b010, 3'b111, 1'b1, 1'b1, 2'b10, 3'b010, 3'b010};
    vecs[2] = '{3'b100, 3'b111, 1'b1, 1'b1, 2'b11, 3'b100, 3'b100};
    vecs[3] = '{3'b001, 3'b110, 1'b1, 1'b0, 2'b00, 3'b001, 3'b000};
    vecs[4] = '{3'b101, 3'b111, 1'b1, 1'b1, 2'b11, 3'b101, 3'b100};
    vecs[5] = '{3'b110, 3'b011, 1'b1, 1'b1, 2'b10, 3'b110, 3'b010};
    vecs[6] = '{3'b010, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010, 3'b000};

    // Clock/reset
    in_RST      = 1'b1;
    bus.in_IRQ  = 3'b000;
    bus.in_mask = 3'b111;
    bus.in_NIE  = 1'b1;
    bus.in_hold = 1'b0;
    bus.in_eret = 1'b0;
    bus.in_IG   = 4'b0000;
    #1;
    chk("rst_bk",      32'(bus.out_BK),      32'(0));
    chk("rst_code",    32'(bus.out_code),    32'(0));
    chk("rst_pending", 32'(bus.out_pending), 32'(0));
    chk("rst_insvc",   32'(bus.out_insvc),   32'(0));
    chk("rst_busy",    32'(bus.out_busy),    32'(0));
    ticks(2);
    in_RST = 1'b0;
    tick();

    // Table-driven single requests: pending at edge 3, break at edge 4, then ERET/IG clears
    for (int i = 0; i < 7; i++) begin
      bus.in_mask = vecs[i].mask;
      bus.in_NIE  = vecs[i].nie;
      if (vecs[i].bk) exp_q.push_back(vecs[i].code);
      pulse_irq(vecs[i].irq);
      ticks(2);
      chk($sformatf("v%0d_pend_e3", i), 32'(bus.out_pending), 32'(vecs[i].pend));
      chk($sformatf("v%0d_bk_e3", i),   32'(bus.out_BK),      32'(0));
      tick();
      chk($sformatf("v%0d_bk", i),      32'(bus.out_BK),      32'(vecs[i].bk));
      chk($sformatf("v%0d_code", i),    32'(bus.out_code),    32'(vecs[i].code));
      chk($sformatf("v%0d_insvc", i),   32'(bus.out_insvc),   32'(vecs[i].insvc));
      chk($sformatf("v%0d_pend", i),    32'(bus.out_pending), 32'(vecs[i].pend));
      chk($sformatf("v%0d_busy", i),    32'(bus.out_busy),    32'(vecs[i].bk));
      tick();
      retire(vecs[i].irq);
      chk($sformatf("v%0d_clr_pend", i),  32'(bus.out_pending), 32'(0));
      chk($sformatf("v%0d_clr_insvc", i), 32'(bus.out_insvc),   32'(0));
      chk($sformatf("v%0d_clr_busy", i),  32'(bus.out_busy),    32'(0));
    end
    bus.in_mask = 3'b111;
    bus.in_NIE  = 1'b1;

    // Simultaneous sources 2 and 0: 2 first, 0 only after source 2 is acknowledged
    exp_q.push_back(2'b11);
    pulse_irq(3'b101);
    ticks(3);
    chk("pri_bk1",    32'(bus.out_BK),    32'(1));
    chk("pri_code1",  32'(bus.out_code),  32'(3));
    ticks(6);
    chk("pri_wait_bk",    32'(bus.out_BK),      32'(0));
    chk("pri_wait_insvc", 32'(bus.out_insvc),   32'(3'b100));
    chk("pri_wait_pend",  32'(bus.out_pending), 32'(3'b101));
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
    bus.in_IG   = 4'b0100;
    exp_q.push_back(2'b01);
    tick();
    bus.in_IG   = 4'b0000;
    chk("pri_ret_insvc", 32'(bus.out_insvc),   32'(0));
    chk("pri_ret_pend",  32'(bus.out_pending), 32'(3'b001));
    chk("pri_ret_bk",    32'(bus.out_BK),      32'(0));
    tick();
    chk("pri_bk2",    32'(bus.out_BK),    32'(1));
    chk("pri_code2",  32'(bus.out_code),  32'(1));
    chk("pri_insvc2", 32'(bus.out_insvc), 32'(3'b001));
    tick();
    retire(3'b001);
    chk("pri_end_pend", 32'(bus.out_pending), 32'(0));

    // Hold defers the break for 5 cycles, then it fires the cycle after hold drops
    bus.in_hold = 1'b1;
    pulse_irq(3'b010);
    ticks(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_bk_%0d", i), 32'(bus.out_BK), 32'(0));
    end
    bus.in_hold = 1'b0;
    exp_q.push_back(2'b10);
    tick();
    chk("hold_bk",   32'(bus.out_BK),   32'(1));
    chk("hold_code", 32'(bus.out_code), 32'(2));
    tick();
    retire(3'b010);

    // Masked request stays latched and issues once unmasked
    bus.in_mask = 3'b000;
    pulse_irq(3'b001);
    ticks(5);
    chk("mask_bk",   32'(bus.out_BK),      32'(0));
    chk("mask_pend", 32'(bus.out_pending), 32'(3'b001));
    bus.in_mask = 3'b001;
    exp_q.push_back(2'b01);
    wait_bk(2, "mask_release_bk");
    chk("mask_code", 32'(bus.out_code), 32'(1));
    tick();
    retire(3'b001);
    bus.in_mask = 3'b111;

    // Nesting: source 0 in service, then source 2 arrives
    exp_q.push_back(2'b01);
    pulse_irq(3'b001);
    ticks(3);
    chk("nest_bk1",    32'(bus.out_BK),    32'(1));
    chk("nest_insvc1", 32'(bus.out_insvc), 32'(3'b001));
    ticks(2);
`ifdef INT_NEST_EN
    exp_q.push_back(2'b11);
    pulse_irq(3'b100);
    ticks(3);
    chk("nest_bk2",    32'(bus.out_BK),    32'(1));
    chk("nest_code2",  32'(bus.out_code),  32'(3));
    chk("nest_insvc2", 32'(bus.out_insvc), 32'(3'b101));
    tick();
    retire(3'b100);
    chk("nest_ret1_insvc", 32'(bus.out_insvc), 32'(3'b001));
    retire(3'b001);
    chk("nest_ret2_insvc", 32'(bus.out_insvc),   32'(0));
    chk("nest_ret2_pend",  32'(bus.out_pending), 32'(0));
`else
    pulse_irq(3'b100);
    ticks(3);
    chk("nonest_bk",    32'(bus.out_BK),      32'(0));
    chk("nonest_insvc", 32'(bus.out_insvc),   32'(3'b001));
    chk("nonest_pend",  32'(bus.out_pending), 32'(3'b101));
    retire(3'b001);
    chk("nonest_ret_insvc", 32'(bus.out_insvc),   32'(0));
    chk("nonest_ret_pend",  32'(bus.out_pending), 32'(3'b100));
    exp_q.push_back(2'b11);
    tick();
    chk("nonest_bk2",    32'(bus.out_BK),    32'(1));
    chk("nonest_code2",  32'(bus.out_code),  32'(3));
    chk("nonest_insvc2", 32'(bus.out_insvc), 32'(3'b100));
    tick();
    retire(3'b100);
    chk("nonest_end_insvc", 32'(bus.out_insvc), 32'(0));
`endif

    // Reset in the middle of a break, then a line held high through reset
    pulse_irq(3'b010);
    ticks(3);
    chk("rstmid_bk_before", 32'(bus.out_BK), 32'(1));
    bus.in_IRQ = 3'b001;
    in_RST     = 1'b1;
    #1;
    chk("rstmid_bk",      32'(bus.out_BK),      32'(0));
    chk("rstmid_code",    32'(bus.out_code),    32'(0));
    chk("rstmid_pending", 32'(bus.out_pending), 32'(0));
    chk("rstmid_insvc",   32'(bus.out_insvc),   32'(0));
    chk("rstmid_busy",    32'(bus.out_busy),    32'(0));
    ticks(2);
    in_RST = 1'b0;
    exp_q.push_back(2'b01);
    ticks(4);
    chk("rstrel_bk",    32'(bus.out_BK),    32'(1));
    chk("rstrel_code",  32'(bus.out_code),  32'(1));
    chk("rstrel_insvc", 32'(bus.out_insvc), 32'(3'b001));
    tick();
    bus.in_IRQ = 3'b000;
    retire(3'b001);
    ticks(2);

    chk("exp_q_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
